// File: rtl/cache_pkg.sv
// Shared types and constants for the cache front-end arbiter.
package cache_pkg;

    localparam int unsigned ADDR_W                   = 32;
    localparam int unsigned DATA_W                   = 32;
    localparam int unsigned ARB_STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    // One cache access as presented on the c_* bus.
    typedef struct packed {
        logic              write_en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cache_req_t;

endpackage

// File: rtl/cache_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-ported cache,
// with a starvation guard that forces an instruction grant after a run of data grants.
module cache_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT,
    parameter bit          D_FIRST      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_write_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              c_ready,
    output logic              c_write_en,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data,
    input  logic              c_hit,
    input  logic [DATA_W-1:0] c_out
);

    localparam int unsigned      CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    arb_state_t       state_nxt;
    cache_req_t       hold;
    cache_req_t       hold_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;

    cache_req_t       i_pkt;
    cache_req_t       d_pkt;
    cache_req_t       issue;
    logic             grant_i;
    logic             grant_d;

    // The instruction port never writes; its data field is unused.
    assign i_pkt = '{write_en: 1'b0, addr: i_addr, data: '0};
    assign d_pkt = '{write_en: d_write_en, addr: d_addr, data: d_wdata};

    // Idle-cycle winner selection.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            if (!D_FIRST || (starve_cnt == CNT_MAX)) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_i = i_req;
            grant_d = d_req;
        end
    end

    // Next-state, hold capture, starvation count and bus outputs.
    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold;
        starve_cnt_nxt = starve_cnt;
        issue          = '0;
        c_ready        = 1'b0;
        i_done         = 1'b0;
        d_done         = 1'b0;

        if (reset && en) begin
            case (state)
                ARB_IDLE: begin
                    if (grant_i || grant_d) begin
                        issue   = grant_i ? i_pkt : d_pkt;
                        c_ready = 1'b1;
                        if (c_hit) begin
                            i_done = grant_i;
                            d_done = grant_d;
                        end else begin
                            hold_nxt  = issue;
                            state_nxt = grant_i ? ARB_SERVE_I : ARB_SERVE_D;
                        end
                    end
                end
                ARB_SERVE_I: begin
                    issue   = hold;
                    c_ready = 1'b1;
                    if (c_hit) begin
                        i_done    = 1'b1;
                        state_nxt = ARB_IDLE;
                    end
                end
                ARB_SERVE_D: begin
                    issue   = hold;
                    c_ready = 1'b1;
                    if (c_hit) begin
                        d_done    = 1'b1;
                        state_nxt = ARB_IDLE;
                    end
                end
                default: begin
                    state_nxt = ARB_IDLE;
                end
            endcase

            // Counts data completions the instruction port has waited through.
            if (i_done || !i_req) begin
                starve_cnt_nxt = '0;
            end else if (d_done && (starve_cnt != CNT_MAX)) begin
                starve_cnt_nxt = starve_cnt + CNT_W'(1);
            end
        end
    end

    assign c_write_en = issue.write_en;
    assign c_addr     = issue.addr;
    assign c_data     = issue.data;
    assign i_rdata    = i_done ? c_out : '0;
    assign d_rdata    = d_done ? c_out : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            hold       <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            hold       <= hold_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed vector table, corner-case
// sequences, and randomized traffic against a transaction-level reference model.
module tb_cache_arbiter;

    localparam int unsigned STARVE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        c_ready;
    logic        c_write_en;
    logic [31:0] c_addr;
    logic [31:0] c_data;
    logic        c_hit;
    logic [31:0] c_out;

    int n_vec = 0;
    int n_err = 0;

    cache_arbiter #(.STARVE_LIMIT(STARVE), .D_FIRST(1'b1)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .en         (en),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_done     (i_done),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_write_en (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_done     (d_done),
        .d_rdata    (d_rdata),
        .c_ready    (c_ready),
        .c_write_en (c_write_en),
        .c_addr     (c_addr),
        .c_data     (c_data),
        .c_hit      (c_hit),
        .c_out      (c_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        idone;
        logic        ddone;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } obs_t;

    typedef struct packed {
        logic        en;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        hit;
        logic [31:0] cout;
    } stim_t;

    typedef struct {
        string name;
        stim_t s;
        obs_t  e;
        bit    dc_data;
    } vec_t;

    vec_t tbl[$];

    // Transaction-level model: who owns the cache, what was captured, how long I has waited.
    int          m_owner;   // 0 none, 1 instruction, 2 data
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_we;
    int          m_starve;

    function automatic stim_t S(logic e, logic ir, logic [31:0] ia, logic dr, logic dw,
                                logic [31:0] da, logic [31:0] dd, logic h, logic [31:0] co);
        stim_t s;
        s.en = e; s.ireq = ir; s.iaddr = ia; s.dreq = dr; s.dwe = dw;
        s.daddr = da; s.dwdata = dd; s.hit = h; s.cout = co;
        return s;
    endfunction

    function automatic obs_t O(logic r, logic w, logic [31:0] a, logic [31:0] d,
                               logic idn, logic ddn, logic [31:0] ir, logic [31:0] dr);
        obs_t o;
        o.ready = r; o.we = w; o.addr = a; o.data = d;
        o.idone = idn; o.ddone = ddn; o.irdata = ir; o.drdata = dr;
        return o;
    endfunction

    function automatic vec_t V(string n, stim_t s, obs_t e, bit dc);
        vec_t v;
        v.name = n; v.s = s; v.e = e; v.dc_data = dc;
        return v;
    endfunction

    function automatic obs_t mask_for(obs_t e, bit dc_data, bit dc_we);
        obs_t m;
        m = '1;
        if (!e.ready) begin
            m.addr = '0;
            m.data = '0;
        end
        if (dc_data) m.data = '0;
        if (dc_we)   m.we   = 1'b0;
        return m;
    endfunction

    function automatic obs_t obs_now();
        obs_t o;
        o.ready = c_ready; o.we = c_write_en; o.addr = c_addr; o.data = c_data;
        o.idone = i_done; o.ddone = d_done; o.irdata = i_rdata; o.drdata = d_rdata;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t exp, input obs_t mask);
        obs_t act;
        act = obs_now();
        n_vec++;
        if ((act & mask) !== (exp & mask)) begin
            n_err++;
            $display("FAIL %s: got %h want %h mask %h", name, act, exp, mask);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        en = s.en; i_req = s.ireq; i_addr = s.iaddr; d_req = s.dreq; d_we = s.dwe;
        d_addr = s.daddr; d_wdata = s.dwdata; c_hit = s.hit; c_out = s.cout;
    endtask

    task automatic model_reset();
        m_owner = 0; m_addr = '0; m_data = '0; m_we = 1'b0; m_starve = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(S(1, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF));
        model_reset();
        @(negedge clk);
        #1 check_obs("reset_state", '0, mask_for('0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        c_hit = 1'b0;
    endtask

    // Expected outputs this cycle from the model plus current inputs.
    task automatic model_expect(output obs_t e, output obs_t m, output int who);
        e   = '0;
        who = 0;
        if (!rst_n) begin
            m = mask_for(e, 1'b1, 1'b0);
            return;
        end
        if (!en) begin
            m = mask_for(e, 1'b1, 1'b1);
            return;
        end
        if (m_owner == 0) begin
            if (i_req && d_req) who = (m_starve >= STARVE) ? 1 : 2;
            else if (i_req)     who = 1;
            else if (d_req)     who = 2;
            if (who == 1) begin
                e.addr = i_addr; e.we = 1'b0;
            end else if (who == 2) begin
                e.addr = d_addr; e.we = d_we; e.data = d_wdata;
            end
        end else begin
            who = m_owner;
            e.addr = m_addr; e.we = m_we; e.data = m_data;
        end
        e.ready = (who != 0);
        if (who != 0 && c_hit) begin
            if (who == 1) begin
                e.idone = 1'b1; e.irdata = c_out;
            end else begin
                e.ddone = 1'b1; e.drdata = c_out;
            end
        end
        m = mask_for(e, who == 1, 1'b0);
    endtask

    task automatic model_commit(input obs_t e, input int who);
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!en) return;
        if (m_owner == 0) begin
            if (who != 0 && !c_hit) begin
                m_owner = who;
                m_addr  = (who == 1) ? i_addr : d_addr;
                m_data  = (who == 1) ? 32'h0 : d_wdata;
                m_we    = (who == 2) && d_we;
            end
        end else if (c_hit) begin
            m_owner = 0;
        end
        if (e.idone || !i_req)                  m_starve = 0;
        else if (e.ddone && m_starve < STARVE)  m_starve = m_starve + 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e;
        obs_t m;
        int   who;

        rst_n = 1'b0;
        drive(S(1, 0, 0, 0, 0, 0, 0, 0, 0));
        do_reset();

        // Directed table, applied back to back from reset.
        tbl.push_back(V("idle",          S(1,0,32'h0,0,0,32'h0,32'h0,0,32'h0),
                                         O(0,0,32'h0,32'h0,0,0,32'h0,32'h0), 0));
        tbl.push_back(V("i_hit_same",    S(1,1,32'h40,0,0,32'h0,32'h0,1,32'h1111_2222),
                                         O(1,0,32'h40,32'h0,1,0,32'h1111_2222,32'h0), 1));
        tbl.push_back(V("hit_no_ready",  S(1,0,32'h0,0,0,32'h0,32'h0,1,32'hAAAA_AAAA),
                                         O(0,0,32'h0,32'h0,0,0,32'h0,32'h0), 0));
        tbl.push_back(V("d_wr_issue",    S(1,0,32'h0,1,1,32'h1000,32'hDEAD_BEEF,0,32'h0),
                                         O(1,1,32'h1000,32'hDEAD_BEEF,0,0,32'h0,32'h0), 0));
        tbl.push_back(V("d_wr_wait1",    S(1,0,32'h0,1,1,32'h1000,32'hDEAD_BEEF,0,32'h0),
                                         O(1,1,32'h1000,32'hDEAD_BEEF,0,0,32'h0,32'h0), 0));
        tbl.push_back(V("d_wr_wait2",    S(1,0,32'h0,1,0,32'h5555,32'h0,0,32'h0),
                                         O(1,1,32'h1000,32'hDEAD_BEEF,0,0,32'h0,32'h0), 0));
        tbl.push_back(V("d_wr_done",     S(1,0,32'h0,1,1,32'h1000,32'hDEAD_BEEF,1,32'h0BAD_F00D),
                                         O(1,1,32'h1000,32'hDEAD_BEEF,0,1,32'h0,32'h0BAD_F00D), 0));
        tbl.push_back(V("d_rd_issue",    S(1,0,32'h0,1,0,32'h3000,32'h77,0,32'h0),
                                         O(1,0,32'h3000,32'h77,0,0,32'h0,32'h0), 0));
        tbl.push_back(V("d_drop_hold",   S(1,0,32'h0,0,0,32'h2000,32'h0,0,32'h0),
                                         O(1,0,32'h3000,32'h77,0,0,32'h0,32'h0), 0));
        tbl.push_back(V("d_drop_done",   S(1,0,32'h0,0,0,32'h2000,32'h0,1,32'hCAFE_0001),
                                         O(1,0,32'h3000,32'h77,0,1,32'h0,32'hCAFE_0001), 0));
        tbl.push_back(V("idle_again",    S(1,0,32'h0,0,0,32'h0,32'h0,0,32'h0),
                                         O(0,0,32'h0,32'h0,0,0,32'h0,32'h0), 0));
        tbl.push_back(V("i_serve_issue", S(1,1,32'h80,0,0,32'h0,32'h0,0,32'h0),
                                         O(1,0,32'h80,32'h0,0,0,32'h0,32'h0), 1));
        tbl.push_back(V("i_hold_dreq",   S(1,0,32'h0,1,1,32'h9000,32'h99,0,32'h0),
                                         O(1,0,32'h80,32'h0,0,0,32'h0,32'h0), 1));
        tbl.push_back(V("i_serve_done",  S(1,0,32'h0,1,1,32'h9000,32'h99,1,32'h1234_5678),
                                         O(1,0,32'h80,32'h0,1,0,32'h1234_5678,32'h0), 1));
        tbl.push_back(V("d_after_i",     S(1,0,32'h0,1,1,32'h9000,32'h99,1,32'h5),
                                         O(1,1,32'h9000,32'h99,0,1,32'h0,32'h5), 0));
        tbl.push_back(V("tie_d_first",   S(1,1,32'h44,1,0,32'h4400,32'h0,1,32'h66),
                                         O(1,0,32'h4400,32'h0,0,1,32'h0,32'h66), 0));

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].s);
            #1 check_obs(tbl[k].name, tbl[k].e, mask_for(tbl[k].e, tbl[k].dc_data, !tbl[k].e.ready));
        end

        // Starvation guard: both ports continuously requesting, every access hits.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(S(1, 1, 32'h10, 1, 0, 32'h20, 32'h0, 1, 32'(k)));
            #1 check_val($sformatf("starve_order_%0d", k), {30'd0, i_done, d_done},
                         (k % 5 == 4) ? 32'd2 : 32'd1);
        end

        // Asynchronous reset while serving the instruction port.
        do_reset();
        @(negedge clk);
        drive(S(1, 1, 32'h100, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        #1 check_val("rst_serve_issue", {31'd0, c_ready}, 32'd1);
        @(negedge clk);
        i_addr = 32'h180;
        #1 check_val("rst_serve_hold", c_addr, 32'h100);
        #1 c_hit = 1'b1;
        rst_n = 1'b0;
        #1 check_val("rst_outputs_drop", {28'd0, c_ready, c_write_en, i_done, d_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(S(1, 1, 32'h200, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        #1 check_val("rst_rearb_addr", c_addr, 32'h200);
        @(negedge clk);
        c_hit = 1'b1;
        c_out = 32'h2222;
        #1 check_val("rst_rearb_done", {31'd0, i_done}, 32'd1);

        // Enable low while serving the data port, with the cache signalling completion.
        do_reset();
        @(negedge clk);
        drive(S(1, 0, 32'h0, 1, 1, 32'h700, 32'h7, 0, 32'h0));
        #1 check_val("en_issue", {31'd0, c_ready}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(S(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h55));
            #1 check_val($sformatf("en_frozen_%0d", k), {30'd0, c_ready, d_done}, 32'd0);
        end
        @(negedge clk);
        drive(S(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0));
        #1 check_val("en_resume_addr", c_addr, 32'h700);
        check_val("en_resume_ctl", {30'd0, c_ready, c_write_en}, 32'd3);
        @(negedge clk);
        c_hit = 1'b1;
        c_out = 32'h77;
        #1 check_val("en_done_data", d_done ? d_rdata : 32'hFFFF_FFFF, 32'h77);
        @(negedge clk);
        c_hit = 1'b0;
        #1 check_val("en_back_idle", {31'd0, c_ready}, 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_n   = ($urandom_range(0, 199) != 0);
            en      = ($urandom_range(0, 9) != 0);
            i_req   = ($urandom_range(0, 9) < 6);
            i_addr  = $urandom;
            d_req   = ($urandom_range(0, 9) < 6);
            d_we    = $urandom_range(0, 1) != 0;
            d_addr  = $urandom;
            d_wdata = $urandom;
            c_hit   = ($urandom_range(0, 9) < 4);
            c_out   = $urandom;
            #1 model_expect(e, m, who);
            check_obs($sformatf("rand_%0d", n), e, m);
            @(posedge clk);
            model_commit(e, who);
        end

        @(negedge clk);
        rst_n = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data-port grants allowed while the instruction port waits.
REQ-002 Parameter D_FIRST, default 1: 1 = data port wins ties, 0 = instruction port wins ties.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; reset=0 clears all state immediately.
REQ-005 en  input  1  global enable; 0 freezes all state.
REQ-006 i_req  input  1  instruction-fetch read request.
REQ-007 i_addr  input  32  instruction-fetch address.
REQ-008 i_done  output  1  one-cycle pulse: instruction access complete.
REQ-009 i_rdata  output  32  instruction data, valid while i_done=1.
REQ-010 d_req  input  1  data-port request.
REQ-011 d_write_en  input  1  data-port write, qualified by d_req.
REQ-012 d_addr, d_wdata  input  32 each  data-port address and write data.
REQ-013 d_done  output  1  one-cycle pulse: data access complete.
REQ-014 d_rdata  output  32  data-port read data, valid while d_done=1.
REQ-015 c_ready, c_write_en  output  1 each  cache request strobe and write select.
REQ-016 c_addr, c_data  output  32 each  cache address and write data.
REQ-017 c_hit  input  1  cache one-cycle completion.
REQ-018 c_out  input  32  cache read data.

Function
REQ-019 FSM states are ARB_IDLE, ARB_SERVE_I and ARB_SERVE_D.
REQ-020 In ARB_IDLE with en=1 and any request, the winner's fields drive c_* combinationally in the same cycle, with c_ready=1.
REQ-021 Winner rule: if only one request is present, that port wins; if both are present, the D_FIRST port wins, except that the instruction port wins when starve_cnt==STARVE_LIMIT.
REQ-022 In ARB_IDLE, c_hit=1 in the issuing cycle pulses the winner's done and leaves the state at ARB_IDLE.
REQ-023 In ARB_IDLE, c_hit=0 in the issuing cycle latches the winner's addr/data/write_en into hold registers and moves to that winner's SERVE state.
REQ-024 In ARB_SERVE_x, c_* are driven from the hold registers with c_ready=1, regardless of the requester's current inputs.
REQ-025 In ARB_SERVE_x, the state holds until c_hit=1; c_hit=1 pulses x_done and moves to ARB_IDLE.
REQ-026 x_rdata = c_out whenever x_done=1; x_rdata = 0 otherwise.
REQ-027 Dropping x_req during ARB_SERVE_x does not abort service; x_done still pulses.
REQ-028 The instruction port always has c_write_en=0.
REQ-029 At most one of i_done, d_done is 1 in any cycle.
REQ-030 starve_cnt is $clog2(STARVE_LIMIT+1) bits wide and saturates at STARVE_LIMIT.
REQ-031 starve_cnt increments on each d_done while i_req=1, and clears on i_done or when i_req=0.
REQ-032 A requester holding req=1 at the cycle of its own done is treated as a new request in the next ARB_IDLE cycle; there is no back-to-back merge.
REQ-033 With en=0: c_ready=0, both done outputs 0, and state, hold registers and starve_cnt unchanged.
REQ-034 c_hit arriving while c_ready=0 is ignored.
REQ-035 Outside ARB_IDLE, c_ready and c_* follow REQ-024, and c_hit completes only the latched port.

Reset
REQ-036 reset=0 forces ARB_IDLE, clears hold registers and starve_cnt to 0, and forces c_ready, c_write_en, i_done and d_done to 0 asynchronously.
REQ-037 Reset asserted during ARB_SERVE_x abandons the access with no done pulse; the requester re-issues after reset.
REQ-038 The first arbitration occurs in the first clk edge cycle after reset returns to 1.

Structure
REQ-039 The arb_state_t enum and ARB_STARVE_LIMIT_DEFAULT constant belong in the shared cache_pkg package.
REQ-040 The block is a single module with no sub-module; the hold registers and the starve counter are inline.
REQ-041 The block sits directly upstream of the cache: its c_* ports connect 1:1 to the cache ready/write_en/addr/data/hit/out ports.

Verification
REQ-042 Single i_req to 0x0000_0040 with c_hit=1 the same cycle -> i_done=1 in that cycle, i_rdata=c_out, FSM stays ARB_IDLE.
REQ-043 d_req write to 0x0000_1000 with data 0xDEADBEEF, c_hit=0 for 3 cycles then 1 -> c_addr/c_data held stable 4 cycles; d_done pulses once on cycle 4.
REQ-044 i_req and d_req both continuous, D_FIRST=1, STARVE_LIMIT=4 -> grant order D,D,D,D,I then repeats.
REQ-045 d_req dropped 1 cycle after entering ARB_SERVE_D, while d_addr changes to 0x0000_2000 -> c_addr stays at the latched address; d_done still pulses.
REQ-046 reset=0 mid ARB_SERVE_I -> c_ready=0 immediately with no i_done; after release, i_req re-arbitrates cleanly.
REQ-047 en=0 for 2 cycles during ARB_SERVE_D while c_hit=1 -> no done and state unchanged; completion occurs after en returns to 1.
